btc_dec_ctrl_es: RTL and testbench

- Next-generation BTC iterative decoder sequencer.
- Runs alternating column and row half-iterations over a pDEC_NUM-way banked LLR buffer, with early stop when a full iteration reports no decoder failure.
- Runtime code geometry and iteration count are port-driven and latched per block; alpha scales come from ports.
- Sits between the input/work buffer, the pDEC_NUM component decoders and the output buffer.

---
 rtl/btc_dec_ctrl_es.sv | 203 ++++++++++++++++++++
 tb/tb_btc_dec_ctrl_es.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/btc_dec_ctrl_es.sv
// BTC iterative decoder sequencer: alternating column/row half-iterations over a
// pDEC_NUM-way banked LLR buffer, with optional early stop on a fail-free iteration.
module btc_dec_ctrl_es #(
  parameter int pDEC_NUM = 8,
  parameter int pCOL_W   = 6,
  parameter int pROW_W   = 6,
  parameter int pITER_W  = 5,
  parameter int pALPHA_W = 4,
  parameter int pADDR_W  = pCOL_W + pROW_W - $clog2(pDEC_NUM)
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic                iclkena,
  input  logic [pROW_W:0]     irow_len,
  input  logic [pCOL_W:0]     icol_len,
  input  logic [pCOL_W:0]     icol_data_len,
  input  logic [pITER_W-1:0]  iNiter,
  input  logic                ies_ena,
  input  logic [pALPHA_W-1:0] ialpha_first,
  input  logic [pALPHA_W-1:0] ialpha_col,
  input  logic [pALPHA_W-1:0] ialpha_row,
  input  logic                irbuf_full,
  output logic                obuf_rempty,
  input  logic                iwbuf_empty,
  output logic [pADDR_W-1:0]  obuf_addr,
  output logic                orow_mode,
  input  logic                idec_busy,
  output logic [pDEC_NUM-1:0] odec_val,
  output logic                odec_sof,
  output logic                odec_sop,
  output logic                odec_eop,
  output logic                odec_eof,
  output logic                odec_mask,
  output logic [pALPHA_W-1:0] odec_alpha,
  input  logic                idecfail,
  output logic                ostart_iter,
  output logic                olast_iter,
  output logic [pITER_W-1:0]  oiter_used,
  output logic                oearly_stop
);

  localparam int lp_SEL_W = $clog2(pDEC_NUM);
  localparam int lp_WRD_W = pROW_W - lp_SEL_W;

  typedef enum logic [2:0] {
    ST_RESET, ST_WAIT, ST_DO_COL, ST_WAIT_COL, ST_WAIT_O, ST_DO_ROW, ST_WAIT_ROW, ST_DONE
  } state_t;

  state_t               r_state, w_nxt;
  logic [pCOL_W-1:0]    r_row;
  logic [lp_WRD_W-1:0]  r_word;
  logic [lp_WRD_W-1:0]  r_word_m1;
  logic [pCOL_W-1:0]    r_col_m1;
  logic [pCOL_W:0]      r_data_len;
  logic [pITER_W-1:0]   r_niter;
  logic [pITER_W-1:0]   r_iter_cnt;
  logic                 r_es;
  logic                 r_fail;
  logic                 r_early;
  logic                 r_start_iter;
  logic                 r_last_iter;

  logic [lp_WRD_W:0]    w_words_m1;
  logic [pCOL_W:0]      w_col_m1;
  logic [pITER_W-1:0]   w_iter_inc;
  logic                 w_last;
  logic                 w_finish;
  logic                 w_pass_end;
  logic                 w_sel_last;
  logic                 w_masked;
  logic                 w_in_iter;
  logic                 w_start;
  logic                 w_unused;

  assign w_words_m1 = irow_len[pROW_W:lp_SEL_W] - (lp_WRD_W+1)'(1);
  assign w_col_m1   = icol_len - (pCOL_W+1)'(1);
  assign w_unused   = ^{irow_len[lp_SEL_W-1:0], w_words_m1[lp_WRD_W], w_col_m1[pCOL_W]};

  assign w_iter_inc = r_iter_cnt + pITER_W'(1);
  assign w_last     = (w_iter_inc == r_niter);
  // A failure reported in the WAIT_ROW exit cycle still vetoes the early stop.
  assign w_finish   = w_last | (r_es & ~(r_fail | idecfail));
  assign w_pass_end = (r_row == r_col_m1) && (r_word == r_word_m1);
  assign w_sel_last = &r_row[lp_SEL_W-1:0];
  assign w_masked   = ({1'b0, r_row} >= r_data_len);
  assign w_in_iter  = (r_state inside {ST_DO_COL, ST_WAIT_COL, ST_WAIT_O, ST_DO_ROW, ST_WAIT_ROW});
  assign w_start    = (r_state == ST_WAIT) && irbuf_full;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_RESET:    w_nxt = ST_WAIT;
      ST_WAIT:     if (irbuf_full)                     w_nxt = ST_DO_COL;
      ST_DO_COL:   if (w_pass_end)                     w_nxt = ST_WAIT_COL;
      ST_WAIT_COL: if (!idec_busy)                     w_nxt = ST_WAIT_O;
      ST_WAIT_O:   if (iwbuf_empty || !(w_last | r_es)) w_nxt = ST_DO_ROW;
      ST_DO_ROW:   if (w_pass_end)                     w_nxt = ST_WAIT_ROW;
      ST_WAIT_ROW: if (!idec_busy)                     w_nxt = w_finish ? ST_DONE : ST_DO_COL;
      ST_DONE:     w_nxt = ST_WAIT;
      default:     w_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_state      <= ST_RESET;
      r_row        <= '0;
      r_word       <= '0;
      r_word_m1    <= '0;
      r_col_m1     <= '0;
      r_data_len   <= '0;
      r_niter      <= '0;
      r_iter_cnt   <= '0;
      r_es         <= 1'b0;
      r_fail       <= 1'b0;
      r_early      <= 1'b0;
      r_start_iter <= 1'b0;
      r_last_iter  <= 1'b0;
    end else if (iclkena) begin
      // NOTE: non-blocking everywhere here so every term reads pre-edge state.
      r_state      <= w_nxt;
      r_start_iter <= (w_nxt == ST_DO_COL) && (r_state != ST_DO_COL);
      r_last_iter  <= ((w_nxt == ST_DO_ROW) || (w_nxt == ST_WAIT_ROW)) && (w_last | r_es);

      if (w_start) begin
        r_word_m1  <= w_words_m1[lp_WRD_W-1:0];
        r_col_m1   <= w_col_m1[pCOL_W-1:0];
        r_data_len <= icol_data_len;
        r_niter    <= (iNiter == '0) ? pITER_W'(1) : iNiter;
        r_es       <= ies_ena;
        r_iter_cnt <= '0;
        r_early    <= 1'b0;
      end else if ((r_state == ST_WAIT_ROW) && !idec_busy) begin
        r_iter_cnt <= w_iter_inc;
        if (w_finish) r_early <= ~w_last;
      end

      if ((w_nxt == ST_DO_COL) && (r_state != ST_DO_COL)) r_fail <= 1'b0;
      else if (idecfail && w_in_iter)                      r_fail <= 1'b1;

      // Column pass walks rows inside each word; row pass walks banks, then words, then row groups.
      if (r_state == ST_DO_COL) begin
        if (r_row == r_col_m1) begin
          r_row  <= '0;
          r_word <= (r_word == r_word_m1) ? '0 : r_word + lp_WRD_W'(1);
        end else begin
          r_row  <= r_row + pCOL_W'(1);
        end
      end else if (r_state == ST_DO_ROW) begin
        if (w_pass_end) begin
          r_row  <= '0;
          r_word <= '0;
        end else if (w_sel_last) begin
          if (r_word == r_word_m1) begin
            r_word <= '0;
            r_row  <= r_row + pCOL_W'(1);
          end else begin
            r_word <= r_word + lp_WRD_W'(1);
            r_row  <= {r_row[pCOL_W-1:lp_SEL_W], {lp_SEL_W{1'b0}}};
          end
        end else begin
          r_row  <= r_row + pCOL_W'(1);
        end
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case infers a latch.
    odec_val   = '0;
    odec_sof   = 1'b0;
    odec_sop   = 1'b0;
    odec_eop   = 1'b0;
    odec_eof   = 1'b0;
    odec_mask  = 1'b0;
    odec_alpha = '0;
    if (r_state == ST_DO_COL) begin
      odec_val   = '1;
      odec_sop   = (r_row == '0);
      odec_eop   = (r_row == r_col_m1);
      odec_sof   = (r_row == '0) && (r_word == '0);
      odec_eof   = w_pass_end;
      odec_alpha = w_masked ? '0 : ((r_iter_cnt == '0) ? ialpha_first : ialpha_col);
    end else if (r_state == ST_DO_ROW) begin
      odec_val   = pDEC_NUM'(1) << r_row[lp_SEL_W-1:0];
      odec_sop   = (r_word == '0);
      odec_eop   = (r_word == r_word_m1);
      odec_sof   = (r_row == '0) && (r_word == '0);
      odec_eof   = w_pass_end;
      odec_mask  = w_masked;
      odec_alpha = ialpha_row;
    end
  end

  assign obuf_addr   = {r_row, r_word};
  assign obuf_rempty = (r_state == ST_DONE);
  assign orow_mode   = (r_state == ST_DO_ROW) || (r_state == ST_WAIT_ROW);
  assign ostart_iter = r_start_iter;
  assign olast_iter  = r_last_iter;
  assign oiter_used  = r_iter_cnt;
  assign oearly_stop = r_early;

endmodule

// File: tb/tb_btc_dec_ctrl_es.sv
// Directed bench for btc_dec_ctrl_es with 4 banks: per-block vector table plus
// clock-enable freeze and mid-row-pass reset sequences.
module tb_btc_dec_ctrl_es;

  localparam int D = 4;
  localparam logic [3:0] A_FIRST = 4'd3;
  localparam logic [3:0] A_COL   = 4'd5;
  localparam logic [3:0] A_ROW   = 4'd9;
  localparam logic [31:0] CARE_ALL = 32'hFFFF_FFFF;
  localparam logic [31:0] CARE_COL = ~(32'h1 << 18);

  logic       iclk = 1'b0;
  logic       ireset, iclkena;
  logic [6:0] irow_len, icol_len, icol_data_len;
  logic [4:0] iNiter;
  logic       ies_ena, irbuf_full, iwbuf_empty, idec_busy, idecfail;
  logic       obuf_rempty, orow_mode, odec_sof, odec_sop, odec_eop, odec_eof, odec_mask;
  logic       ostart_iter, olast_iter, oearly_stop;
  logic [9:0] obuf_addr;
  logic [3:0] odec_val, odec_alpha;
  logic [4:0] oiter_used;

  btc_dec_ctrl_es #(.pDEC_NUM(D)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .irow_len(irow_len), .icol_len(icol_len), .icol_data_len(icol_data_len),
    .iNiter(iNiter), .ies_ena(ies_ena),
    .ialpha_first(A_FIRST), .ialpha_col(A_COL), .ialpha_row(A_ROW),
    .irbuf_full(irbuf_full), .obuf_rempty(obuf_rempty), .iwbuf_empty(iwbuf_empty),
    .obuf_addr(obuf_addr), .orow_mode(orow_mode), .idec_busy(idec_busy),
    .odec_val(odec_val), .odec_sof(odec_sof), .odec_sop(odec_sop), .odec_eop(odec_eop),
    .odec_eof(odec_eof), .odec_mask(odec_mask), .odec_alpha(odec_alpha),
    .idecfail(idecfail), .ostart_iter(ostart_iter), .olast_iter(olast_iter),
    .oiter_used(oiter_used), .oearly_stop(oearly_stop)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    int       row_len, col_len, data_len, niter;
    bit       es;
    bit [7:0] fail_mask, late_mask;
    int       busy, stall, freeze_at, exp_used;
    bit       exp_early;
  } vec_t;

  vec_t vecs[9];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int addr, input logic [3:0] val,
                                     input logic sop, eop, sof, eof, mask,
                                     input logic [3:0] alpha, input logic rm, st, li, re);
    logic [9:0] a;
    a = 10'(addr);
    return {5'd0, re, li, st, rm, alpha, mask, eof, sof, eop, sop, val, a};
  endfunction

  function automatic logic [31:0] act_vec();
    return pk(int'(obuf_addr), odec_val, odec_sop, odec_eop, odec_sof, odec_eof, odec_mask,
              odec_alpha, orow_mode, ostart_iter, olast_iter, obuf_rempty);
  endfunction

  task automatic run_block(input int k, input vec_t v, input int abort_at);
    int w_n, c_n, n_it, idx, gap, stall_eff, row;
    bit last, done, li;
    logic [3:0] a;
    logic [31:0] e;
    w_n  = v.row_len / D;
    c_n  = v.col_len;
    n_it = (v.niter == 0) ? 1 : v.niter;
    irow_len = 7'(v.row_len); icol_len = 7'(v.col_len); icol_data_len = 7'(v.data_len);
    iNiter = 5'(v.niter); ies_ena = v.es;
    idecfail = 0; idec_busy = 0; iwbuf_empty = 1; irbuf_full = 1;
    tick();
    irbuf_full = 0;
    for (int it = 0; it < n_it; it++) begin
      last      = (it == n_it - 1);
      done      = last || (v.es && !v.fail_mask[it] && !v.late_mask[it]);
      li        = last || v.es;
      stall_eff = li ? v.stall : 0;
      idecfail  = v.fail_mask[it];
      iwbuf_empty = (v.stall == 0);
      idx = 0;
      for (int w = 0; w < w_n; w++) begin
        for (int r = 0; r < c_n; r++) begin
          a = (r >= v.data_len) ? 4'd0 : ((it == 0) ? A_FIRST : A_COL);
          e = pk((r << 4) | w, 4'hF, r == 0, r == c_n - 1, idx == 0, idx == c_n * w_n - 1,
                 1'b0, a, 1'b0, idx == 0, 1'b0, 1'b0);
          check($sformatf("v%0d it%0d col%0d", k, it, idx), act_vec() & CARE_COL, e & CARE_COL);
          if (idx == v.freeze_at) begin
            iclkena = 0;
            for (int f = 0; f < 3; f++) begin
              tick();
              check($sformatf("v%0d freeze%0d", k, f), act_vec() & CARE_COL, e & CARE_COL);
            end
            iclkena = 1;
          end
          if (idx == c_n * w_n - 1 && v.busy > 0) idec_busy = 1;
          tick();
          idx++;
        end
      end
      gap = 0;
      while (odec_val == 4'd0 && gap < 64) begin
        check($sformatf("v%0d it%0d gap%0d", k, it, gap), act_vec(),
              pk(0, 4'd0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0));
        gap++;
        if (gap == 1 + v.busy) idec_busy = 0;
        if (stall_eff > 0 && gap == 2 + v.busy + stall_eff) iwbuf_empty = 1;
        tick();
      end
      check($sformatf("v%0d it%0d gap_len", k, it), 32'(gap), 32'(2 + v.busy + stall_eff));
      idx = 0;
      for (int g = 0; g < c_n / D; g++) begin
        for (int w = 0; w < w_n; w++) begin
          for (int s = 0; s < D; s++) begin
            row = g * D + s;
            check($sformatf("v%0d it%0d row%0d", k, it, idx), act_vec() & CARE_ALL,
                  pk((row << 4) | w, 4'(1 << s), w == 0, w == w_n - 1, idx == 0,
                     idx == c_n * w_n - 1, row >= v.data_len, A_ROW, 1'b1, 1'b0, li, 1'b0));
            if (idx == abort_at) begin
              ireset = 1;
              #1;
              check($sformatf("v%0d abort_outs", k), act_vec(), 32'd0);
              check($sformatf("v%0d abort_iter", k), {26'd0, oiter_used, oearly_stop}, 32'd0);
              ireset = 0;
              tick();
              return;
            end
            tick();
            idx++;
          end
        end
      end
      check($sformatf("v%0d it%0d wait_row", k, it), act_vec(),
            pk(0, 4'd0, 0, 0, 0, 0, 0, 4'd0, 1'b1, 1'b0, li, 1'b0));
      if (v.late_mask[it]) idecfail = 1;
      tick();
      if (done) begin
        check($sformatf("v%0d done", k), act_vec(), pk(0, 4'd0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1'b1));
        check($sformatf("v%0d iter_used", k), 32'(oiter_used), 32'(v.exp_used));
        check($sformatf("v%0d early_stop", k), 32'(oearly_stop), 32'(v.exp_early));
        idecfail = 0;
        tick();
        check($sformatf("v%0d idle", k), act_vec(), 32'd0);
        return;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             row col dat nit es  fail   late   bsy stl frz used early
    vecs[0] = '{16, 8, 6, 2, 1'b0, 8'hFF, 8'h00, 0, 0, -1, 2, 1'b0};
    vecs[1] = '{16, 8, 6, 8, 1'b1, 8'h01, 8'h00, 2, 0, -1, 2, 1'b1};
    vecs[2] = '{16, 8, 6, 1, 1'b0, 8'h00, 8'h00, 1, 5,  5, 1, 1'b0};
    vecs[3] = '{16, 8, 6, 0, 1'b0, 8'h00, 8'h00, 0, 0, -1, 1, 1'b0};
    vecs[4] = '{ 4, 4, 4, 1, 1'b0, 8'h00, 8'h00, 0, 0, -1, 1, 1'b0};
    vecs[5] = '{16, 8, 6, 3, 1'b1, 8'hFF, 8'h00, 0, 0, -1, 3, 1'b0};
    vecs[6] = '{16, 8, 6, 4, 1'b1, 8'h00, 8'h00, 0, 0, -1, 1, 1'b1};
    vecs[7] = '{16, 8, 6, 4, 1'b1, 8'h00, 8'h01, 0, 0, -1, 2, 1'b1};
    vecs[8] = '{16, 8, 6, 2, 1'b0, 8'hFF, 8'h00, 0, 3, -1, 2, 1'b0};

    ireset = 1; iclkena = 1; irbuf_full = 0; iwbuf_empty = 1; idec_busy = 0; idecfail = 0;
    irow_len = 0; icol_len = 0; icol_data_len = 0; iNiter = 0; ies_ena = 0;
    repeat (2) @(posedge iclk);
    #1;
    check("reset_outs", act_vec(), 32'd0);
    check("reset_iter", {26'd0, oiter_used, oearly_stop}, 32'd0);
    ireset = 0;
    tick();
    check("post_reset_idle", act_vec(), 32'd0);

    for (int k = 0; k < 9; k++) run_block(k, vecs[k], -1);

    // Abandon a block mid row pass, then restart cleanly from address 0.
    run_block(9, vecs[0], 10);
    run_block(10, vecs[4], -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
